// File: rtl/whack_vga_pkg.sv
// Shared VGA drawing definitions: screen geometry, colour type and draw FSM states.
package whack_vga_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned COLOUR_W = 12;

  typedef logic [COLOUR_W-1:0] colour_t;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} draw_state_t;

endpackage

// File: rtl/pix_delay_pipe.sv
// Fixed-depth shift register carrying {valid, cx, cy} alongside the ROM read latency.
module pix_delay_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/bg_frame_drawer.sv
// Scans a background frame out of a synchronous colour ROM as one VGA pixel write per cycle.
// Optional macro BG_FRAME_DRAWER_COLOUR_KEY_EN suppresses plots whose colour equals KEY_COLOUR.
module bg_frame_drawer
  import whack_vga_pkg::*;
#(
  parameter int unsigned WIDTH    = SCREEN_W,
  parameter int unsigned HEIGHT   = SCREEN_H,
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned COLOUR_W = 12,
  parameter int unsigned ROM_LAT  = 1,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = '0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                abort,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int unsigned PIPE_W = 1 + 8 + 7;

  draw_state_t state, state_nxt;

  logic [7:0] cx;
  logic [6:0] cy;
  logic [1:0] flush_cnt;
  logic       load;
  logic       advance;
  logic       last_pix;
  logic       clr_pipe;
  logic       keyed;

  logic [PIPE_W-1:0] pipe_q;
  logic              p_valid;
  logic [7:0]        p_cx;
  logic [6:0]        p_cy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    clr_pipe  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    last_pix  = (cx == 8'(WIDTH - 1)) && (cy == 7'(HEIGHT - 1));
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
          clr_pipe  = 1'b1;
        end else begin
          advance = 1'b1;
          if (last_pix) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
          clr_pipe  = 1'b1;
        end else if (flush_cnt == 2'(ROM_LAT)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // Back-to-back frames: a start on the done cycle relaunches immediately.
        if (start && !abort) begin
          state_nxt = RUN;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address and column/row advance together; counting freezes on the last pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx       <= '0;
      cy       <= '0;
      rom_addr <= '0;
    end else if (load) begin
      cx       <= '0;
      cy       <= '0;
      rom_addr <= '0;
    end else if (advance && !last_pix) begin
      rom_addr <= rom_addr + ADDR_W'(1);
      if (cx == 8'(WIDTH - 1)) begin
        cx <= '0;
        cy <= cy + 7'd1;
      end else begin
        cx <= cx + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)              flush_cnt <= '0;
    else if (state == FLUSH)  flush_cnt <= flush_cnt + 2'd1;
    else                      flush_cnt <= '0;
  end

  pix_delay_pipe #(
    .DEPTH (ROM_LAT),
    .W     (PIPE_W)
  ) u_pix_delay_pipe (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clr_pipe),
    .d      ({advance, cx, cy}),
    .q      (pipe_q)
  );

  assign {p_valid, p_cx, p_cy} = pipe_q;

`ifdef BG_FRAME_DRAWER_COLOUR_KEY_EN
  assign keyed = (rom_q == KEY_COLOUR);
`else
  assign keyed = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else if (clr_pipe) begin
      plot <= 1'b0;
    end else begin
      plot <= p_valid && !keyed;
      if (p_valid && !keyed) begin
        x      <= p_cx;
        y      <= p_cy;
        colour <= rom_q;
      end
    end
  end

endmodule

// File: doc/bg_frame_drawer.md
Name: bg_frame_drawer

Overview:
- Scans a full background frame out of a synchronous colour ROM and emits one pixel write per cycle toward the VGA adapter's x/y/colour/plot inputs.
- Generates the ROM address, compensates for ROM read latency, and drives x, y, colour and plot aligned with each other.
- Started by the game FSM on each screen change (start screen, game screen); reports busy/done back to it.

Parameters:
- WIDTH, 160, frame width in pixels
- HEIGHT, 120, frame height in pixels
- ADDR_W, 15, ROM address width (must satisfy 2^ADDR_W >= WIDTH*HEIGHT)
- COLOUR_W, 12, colour width (4 bits per channel)
- ROM_LAT, 1, ROM read latency in cycles (range 1..3)
- KEY_COLOUR, 12'h000, transparent colour (used only with the optional feature)

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to draw a frame
- abort  in  1  synchronous cancel of the frame in progress
- rom_addr  out  ADDR_W  address to the background ROM
- rom_q  in  COLOUR_W  ROM data, valid ROM_LAT cycles after rom_addr
- x  out  8  pixel column to the VGA adapter
- y  out  7  pixel row to the VGA adapter
- colour  out  COLOUR_W  pixel colour to the VGA adapter
- plot  out  1  write strobe to the VGA adapter
- busy  out  1  frame in progress, including pipeline drain
- done  out  1  one-cycle pulse after the last plot

Behaviour:
- Reset (async, resetn=0): state IDLE. Outputs rom_addr, x, y, colour, plot, busy and done are all 0. Pipeline valid bits are cleared.
- States:
  - IDLE: start=1 moves to RUN; counters go to 0 and busy=1 from the next cycle.
  - RUN: one address is issued per cycle. After address WIDTH*HEIGHT-1 is issued, move to FLUSH.
  - FLUSH: wait ROM_LAT+1 cycles for the pipeline to drain, then move to DONE.
  - DONE: done=1 for one cycle, busy=0, then return to IDLE.
- Counters:
  - Column cx runs 0..WIDTH-1; row cy runs 0..HEIGHT-1.
  - rom_addr is an incrementing counter; no multiplier.
  - When cx=WIDTH-1, cx wraps to 0 and cy increments.
  - After cx=WIDTH-1 and cy=HEIGHT-1, counting stops.
- Pipeline timing:
  - The cycle after start is accepted is cycle 0. Pixel n's address is driven in cycle n.
  - cx, cy and a valid bit are delayed ROM_LAT cycles, then registered together with rom_q.
  - Pixel n therefore appears on x/y/colour/plot in cycle n+ROM_LAT+1.
  - For defaults: first plot (x=0, y=0) in cycle 2; last plot (x=159, y=119) in cycle 19201; done in cycle 19202; busy high for cycles 0..19201.
- plot is 0 whenever its pipeline slot is invalid. x, y and colour hold their last values when plot=0.
- start while busy=1: ignored, with no restart and no queuing.
- abort=1 in RUN or FLUSH: next state IDLE; all valid bits are cleared, so plot=0 from the next cycle; busy=0; done is not pulsed.
- start and abort in the same cycle while in IDLE: abort wins and the state stays IDLE.
- start in the same cycle as the done pulse: accepted, new frame begins.
- resetn falling mid-frame: immediate return to reset values. No partial-frame completion.

Optional Feature:
- Macro: BG_FRAME_DRAWER_COLOUR_KEY_EN
- Defined: plot is suppressed for any pixel whose rom_q equals KEY_COLOUR. Frame timing and the done cycle are unchanged, so sprite ROMs can be overlaid without erasing the background.
- Undefined: every pixel is plotted and KEY_COLOUR is unused.

Decomposition:
- Shared package whack_vga_pkg holds:
  - SCREEN_W=160, SCREEN_H=120, COLOUR_W=12
  - colour_t typedef
  - draw_state_t enum {IDLE, RUN, FLUSH, DONE}
- Sub-module pix_delay_pipe: a parameterised depth-ROM_LAT shift register for {valid, cx, cy}, with async reset and synchronous clear (driven by abort).

Test Plan:
- Reset: hold resetn=0, pulse start → plot=0, busy=0, done=0, rom_addr=0 throughout.
- Full frame: ROM model returns q=addr[11:0], pulse start →
  - exactly 19200 plots
  - first plot in cycle 2 with x=0, y=0, colour=0
  - the plot with x=159, y=0 is followed by x=0, y=1, colour=160
  - last plot x=159, y=119, colour=12'hAFF (19199 mod 4096)
  - done in cycle 19202 only
- Start while busy: pulse start again at cycle 500 → still 19200 plots, a single done, busy never drops early.
- Abort: abort at cycle 1000 → plot=0 from cycle 1001, busy=0, no done; a new start draws a complete frame from x=0, y=0.
- Async reset mid-frame: drop resetn at cycle 7000 between clock edges → outputs reach 0 before the next edge; after release a new frame works normally.
- Colour key (macro defined, KEY_COLOUR=12'h000): ROM returns 0 on even addresses → 9600 plots, all with odd colour, done still in cycle 19202.
